// File: rtl/sample_checker_if.sv
// AXI4-Stream beat channel between sample_generator and sample_checker.
// The master drives the data/valid/last signals and the slave drives tready.
interface sample_checker_if #(
    parameter int C_S_AXIS_TDATA_WIDTH = 8
);
    logic [C_S_AXIS_TDATA_WIDTH-1:0] tdata;
    logic                            tvalid;
    logic                            tlast;
    logic                            tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/sample_checker.sv
// Stream sink that checks frames of an up-counting pattern with tlast on beat FrameSize-1,
// counting good and bad frames and resynchronising on the next frame boundary after an error.
//
// state | meaning
// IDLE  | not accepting; waits for En=1 and FrameSize!=0 to open a frame
// RUN   | accepting and checking beats of the current frame
// FLUSH | frame already flagged bad; discards beats until tlast
module sample_checker #(
    parameter int C_S_AXIS_TDATA_WIDTH = 8,
    parameter int C_CNT_WIDTH          = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   En,
    input  logic [7:0]             FrameSize,
    sample_checker_if.slave        s_axis,
    output logic [C_CNT_WIDTH-1:0] FrameCount,
    output logic [C_CNT_WIDTH-1:0] ErrCount,
    output logic                   DataErr,
    output logic                   LastErr,
    output logic                   Busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [C_CNT_WIDTH-1:0]          CNT_ONE = {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [C_S_AXIS_TDATA_WIDTH-1:0] EXP_ONE = {{(C_S_AXIS_TDATA_WIDTH-1){1'b0}}, 1'b1};

    state_t                          state, state_n;
    logic [7:0]                      idx, idx_n;
    logic [7:0]                      fsize_q, fsize_n;
    logic [7:0]                      last_idx;
    logic [C_S_AXIS_TDATA_WIDTH-1:0] exp_q, exp_n;
    logic [C_CNT_WIDTH-1:0]          frame_cnt, frame_cnt_n;
    logic [C_CNT_WIDTH-1:0]          err_cnt, err_cnt_n;
    logic                            tready_q;
    logic                            data_err_q, data_err_n;
    logic                            last_err_q, last_err_n;
    logic                            accept, can_start, frame_end;
    logic                            d_err, early_last, missing_last;

    assign accept       = s_axis.tvalid && tready_q;
    assign can_start    = En && (FrameSize != 8'd0);
    assign last_idx     = fsize_q - 8'd1;
    assign d_err        = (s_axis.tdata != exp_q);
    assign early_last   = s_axis.tlast && (idx < last_idx);
    assign missing_last = !s_axis.tlast && (idx == last_idx);

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        exp_n       = exp_q;
        fsize_n     = fsize_q;
        frame_cnt_n = frame_cnt;
        err_cnt_n   = err_cnt;
        data_err_n  = 1'b0;
        last_err_n  = 1'b0;
        frame_end   = 1'b0;

        case (state)
            IDLE: begin
                if (can_start) begin
                    state_n = RUN;
                    fsize_n = FrameSize;
                    idx_n   = 8'd0;
                    exp_n   = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    if (d_err || early_last || missing_last) begin
                        // both pulses may fire, but the frame is only counted bad once
                        data_err_n = d_err;
                        last_err_n = early_last || missing_last;
                        if (err_cnt != '1) err_cnt_n = err_cnt + CNT_ONE;
                        if (s_axis.tlast) frame_end = 1'b1;
                        else              state_n   = FLUSH;
                    end else if (s_axis.tlast) begin
                        if (frame_cnt != '1) frame_cnt_n = frame_cnt + CNT_ONE;
                        frame_end = 1'b1;
                    end else begin
                        idx_n = idx + 8'd1;
                        exp_n = exp_q + EXP_ONE;
                    end
                end
            end
            FLUSH: begin
                if (accept && s_axis.tlast) frame_end = 1'b1;
            end
            default: state_n = IDLE;
        endcase

        // a new frame opens on the very next cycle when still enabled, so there is no bubble
        if (frame_end) begin
            idx_n = 8'd0;
            exp_n = '0;
            if (can_start) begin
                state_n = RUN;
                fsize_n = FrameSize;
            end else begin
                state_n = IDLE;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            idx        <= 8'd0;
            exp_q      <= '0;
            fsize_q    <= 8'd0;
            frame_cnt  <= '0;
            err_cnt    <= '0;
            tready_q   <= 1'b0;
            data_err_q <= 1'b0;
            last_err_q <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            exp_q      <= exp_n;
            fsize_q    <= fsize_n;
            frame_cnt  <= frame_cnt_n;
            err_cnt    <= err_cnt_n;
            tready_q   <= (state_n != IDLE);
            data_err_q <= data_err_n;
            last_err_q <= last_err_n;
        end
    end

    assign s_axis.tready = tready_q;
    assign FrameCount    = frame_cnt;
    assign ErrCount      = err_cnt;
    assign DataErr       = data_err_q;
    assign LastErr       = last_err_q;
    assign Busy          = (idx != 8'd0) || (state == FLUSH);
endmodule

// File: doc/sample_checker.md
# sample_checker

AXI4-Stream slave that sits directly downstream of `sample_generator` and consumes its frames. It checks every accepted frame against the generator's pattern: data counts up from 0 and `tlast` falls on beat `FrameSize-1`. It counts good frames and errors, and resynchronises to the next frame boundary after an error. It serves as the sink stage in the demo design and as the self-checking consumer in generator benches.

## Interface
- `C_S_AXIS_TDATA_WIDTH`, 8: stream data width; the expected-data counter has this width.
- `C_CNT_WIDTH`, 16: width of `FrameCount` and `ErrCount`.
- `Clk` input 1: sole clock; all logic is on its rising edge.
- `Reset` input 1: asynchronous, active-high reset; clears all state and outputs.
- `En` input 1: checker enable; sampled only at frame boundaries.
- `FrameSize` input 8: expected beats per frame; latched when the checker leaves IDLE.
- `S_AXIS_tdata` input C_S_AXIS_TDATA_WIDTH: stream data.
- `S_AXIS_tvalid` input 1: upstream data valid.
- `S_AXIS_tlast` input 1: last beat of the frame.
- `S_AXIS_tready` output 1: checker can accept a beat.
- `FrameCount` output C_CNT_WIDTH: frames received with no error; saturates.
- `ErrCount` output C_CNT_WIDTH: frames with at least one error; saturates.
- `DataErr` output 1: one-cycle pulse on a data mismatch.
- `LastErr` output 1: one-cycle pulse when `tlast` is early or missing.
- `Busy` output 1: high while a frame is in progress (beat index ≠ 0 or in FLUSH).

## Operation
- A beat is accepted when `S_AXIS_tvalid && S_AXIS_tready` at a rising `Clk`. There is no other acceptance condition.
- State IDLE:
  - `tready`=0.
  - Moves to RUN when `En`=1 and `FrameSize`≠0. `FrameSize` is latched into `fsize_q`; beat index `idx`=0; expected data `exp`=0.
  - `FrameSize`=0 keeps the checker in IDLE.
- State RUN (`tready`=1). Checks on each accepted beat:
  - Data check: `tdata`≠`exp` → data error.
  - Last check: `tlast`=1 with `idx`<`fsize_q-1` → early-last error. `tlast`=0 with `idx`=`fsize_q-1` → missing-last error.
  - No error and `tlast`=1: `FrameCount`+1 and the frame ends.
  - No error and no `tlast`: `idx`+1 and `exp`+1; `exp` wraps modulo 2^C_S_AXIS_TDATA_WIDTH.
  - Any error: `ErrCount`+1, exactly once per frame. The flagged pulse(s) assert; data and last errors on the same beat raise both pulses but only one increment.
  - Error beat with `tlast`=1: the frame ends.
  - Error beat with `tlast`=0: go to FLUSH.
- State FLUSH:
  - `tready`=1.
  - Beats are discarded without checking and without further errors.
  - An accepted beat with `tlast`=1 ends the frame.
- Frame end, from RUN or FLUSH:
  - `idx`←0, `exp`←0.
  - If `En`=1 and `FrameSize`≠0: re-latch `FrameSize` and go to RUN.
  - Otherwise go to IDLE.
- `En` deasserted mid-frame has no effect until frame end; the current frame completes with `tready` held at 1.
- `FrameSize` changes mid-frame are ignored until the next latch.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset values:
  - state=IDLE, `S_AXIS_tready`=0, `FrameCount`=0, `ErrCount`=0, `DataErr`=0, `LastErr`=0, `Busy`=0.
  - Internal `idx`, `exp` and `fsize_q` are cleared.
- `Reset` asserted mid-frame clears everything immediately, without waiting for a clock edge. After release, checking resumes with `exp`=0; a partially sent upstream frame is then seen as a data error.
- `S_AXIS_tready` is a registered function of state: high in RUN/FLUSH. It first rises one cycle after IDLE→RUN.
- Pulses and counter updates appear the cycle after the accepted beat, which is 1-cycle latency. Pulses last exactly one cycle.
- Back-to-back frames run with no bubble: the first beat of the next frame may be accepted on the cycle after the previous `tlast`.
- `tvalid` low cycles inside a frame are legal. `idx` and `exp` hold.
- `FrameSize`=1: every beat must carry `tlast` and `tdata`=0.

## Test plan
- Reset, `En`=1, `FrameSize`=8, three clean frames of 0..7 with `tlast` on beat 7 → `FrameCount`=3, `ErrCount`=0, no pulses, `tready` constant 1 after the first frame starts.
- Frame with beat 3 = 0x55 (expect 0x03), `tlast` on beat 7, then a clean frame → one `DataErr` pulse, `ErrCount`=1, `FrameCount`=1; beats 4..7 are flushed without further errors.
- `tlast` on beat 5 with `FrameSize`=8, then a clean frame → `LastErr` pulse, `ErrCount`=1; the next frame is checked from `exp`=0 and counts, giving `FrameCount`=1.
- No `tlast` on beat 7, `tlast` on beat 10 → `LastErr` at beat 7, `ErrCount`=1, FLUSH through beat 10, then RUN.
- `En` dropped on beat 2 of a frame → frame completes, `FrameCount`+1, then `tready`=0 and state IDLE; `Reset` pulsed mid-frame → all outputs 0 asynchronously.
- Force `ErrCount` to 0xFFFE and inject 3 bad frames → `ErrCount` holds at 0xFFFF.
